// File: rtl/axis_sync_join_2_pkg.sv
// Shared definitions for the two-channel AXI-Stream join and its input slices.
package axis_sync_join_2_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;

  // A side may only be consumed when downstream accepts and the partner side has a beat.
  function automatic logic join_pop(input logic out_ready, input logic partner_valid);
    return out_ready & partner_valid;
  endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry skid register slice: main reg feeds the output, skid reg absorbs one
// extra beat so in_ready can be a flop and throughput stays at one beat per cycle.
module axis_skid_slice
  import axis_sync_join_2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  push, pop;

  // Both handshakes are forced low while rst is held so buffered beats are not exposed.
  assign in_ready  = ready_q & ~rst;
  assign out_valid = (state_q != ST_EMPTY) & ~rst;
  assign out_data  = main_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          skid_d  = in_data;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: rtl/axis_sync_join_2.sv
// Joins two AXI-Stream channels into one beat stream; both sides are consumed
// together. LATCH selects a registered skid slice on each input or a pure wire join.
module axis_sync_join_2
  import axis_sync_join_2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_0 = DEF_DATA_WIDTH,
  parameter int unsigned DATA_WIDTH_1 = DEF_DATA_WIDTH,
  parameter bit          LATCH        = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_0_valid,
  output logic                    input_0_ready,
  input  logic [DATA_WIDTH_0-1:0] input_0_data,
  input  logic                    input_1_valid,
  output logic                    input_1_ready,
  input  logic [DATA_WIDTH_1-1:0] input_1_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [DATA_WIDTH_0-1:0] output_data_0,
  output logic [DATA_WIDTH_1-1:0] output_data_1
);

  logic a0, a1;
  logic pop0, pop1;

  assign output_valid = a0 & a1;
  assign pop0         = join_pop(output_ready, a1);
  assign pop1         = join_pop(output_ready, a0);

  generate
    if (LATCH) begin : g_latch
      axis_skid_slice #(
        .DATA_WIDTH(DATA_WIDTH_0)
      ) u_slice_0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (input_0_valid),
        .in_ready (input_0_ready),
        .in_data  (input_0_data),
        .out_valid(a0),
        .out_ready(pop0),
        .out_data (output_data_0)
      );

      axis_skid_slice #(
        .DATA_WIDTH(DATA_WIDTH_1)
      ) u_slice_1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (input_1_valid),
        .in_ready (input_1_ready),
        .in_data  (input_1_data),
        .out_valid(a1),
        .out_ready(pop1),
        .out_data (output_data_1)
      );
    end else begin : g_bypass
      // Stateless variant: clock and reset are intentionally left without loads.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign a0            = input_0_valid;
      assign a1            = input_1_valid;
      assign input_0_ready = pop0;
      assign input_1_ready = pop1;
      assign output_data_0 = input_0_data;
      assign output_data_1 = input_1_data;
    end
  endgenerate

endmodule

// File: tb/tb_axis_sync_join_2.sv
// Directed bench for axis_sync_join_2: registered (LATCH=1) and wire (LATCH=0) variants.
module tb_axis_sync_join_2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, v1, r0, r1, ov, ordy;
  logic [15:0] d0, d1, od0, od1;
  logic        cv0, cv1, cr0, cr1, cov, cordy;
  logic [15:0] cd0, cd1, cod0, cod1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  axis_sync_join_2 #(
    .DATA_WIDTH_0(16),
    .DATA_WIDTH_1(16),
    .LATCH       (1'b1)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .input_0_valid(v0),
    .input_0_ready(r0),
    .input_0_data (d0),
    .input_1_valid(v1),
    .input_1_ready(r1),
    .input_1_data (d1),
    .output_valid (ov),
    .output_ready (ordy),
    .output_data_0(od0),
    .output_data_1(od1)
  );

  axis_sync_join_2 #(
    .DATA_WIDTH_0(16),
    .DATA_WIDTH_1(16),
    .LATCH       (1'b0)
  ) u_comb (
    .clk          (clk),
    .rst          (rst),
    .input_0_valid(cv0),
    .input_0_ready(cr0),
    .input_0_data (cd0),
    .input_1_valid(cv1),
    .input_1_ready(cr1),
    .input_1_data (cd1),
    .output_valid (cov),
    .output_ready (cordy),
    .output_data_0(cod0),
    .output_data_1(cod1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard of accepted input beats, plus hold-stability tracking on the output.
  logic [15:0] q0[$], q1[$], log0[$], log1[$];
  int          n_out = 0, first_in = -1, first_out = 0, last_out = 0;
  logic        stall_q = 1'b0;
  logic [15:0] hold0, hold1;

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", ov, 1);
        check("hold_d0", od0, hold0);
        check("hold_d1", od1, hold1);
      end
      if (ov && ordy) begin
        check("sb_nonempty", (q0.size() != 0 && q1.size() != 0), 1);
        if (q0.size() != 0 && q1.size() != 0) begin
          check("sb_d0", od0, q0.pop_front());
          check("sb_d1", od1, q1.pop_front());
        end
        log0.push_back(od0);
        log1.push_back(od1);
        if (n_out == 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      stall_q = ov && !ordy;
      hold0   = od0;
      hold1   = od1;
      if (v0 && r0) begin
        if (first_in < 0) first_in = cyc;
        q0.push_back(d0);
      end
      if (v1 && r1) q1.push_back(d1);
    end
  end

  task automatic run_stream(input int n, input int p0, input int p1, input int pr,
                            input int budget, input logic [15:0] b0, input logic [15:0] b1);
    int   i0 = 0, i1 = 0, cnt = 0;
    logic a0 = 1'b0, a1 = 1'b0;
    while ((i0 < n || i1 < n || n_out < n) && cnt < budget) begin
      @(posedge clk); #1;
      if (a0) i0++;
      if (a1) i1++;
      if (a0 || !v0) begin
        v0 = (i0 < n) && ($urandom_range(0, 99) < p0);
        d0 = b0 + 16'(i0);
      end
      if (a1 || !v1) begin
        v1 = (i1 < n) && ($urandom_range(0, 99) < p1);
        d1 = b1 + 16'(i1);
      end
      ordy = ($urandom_range(0, 99) < pr);
      cnt++;
      @(negedge clk);
      a0 = v0 && r0;
      a1 = v1 && r1;
    end
    v0 = 1'b0;
    v1 = 1'b0;
    check("stream_done", (i0 >= n && i1 >= n && n_out >= n), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] e0[3];
    logic [15:0] e1[3];
    logic        a0, a1;
    int          k, f0, f1;
    e0 = '{16'h000A, 16'h000B, 16'h000C};
    e1 = '{16'h0001, 16'h0002, 16'h0003};

    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; ordy = 1'b0;
    cv0 = 1'b0; cv1 = 1'b0; cd0 = '0; cd1 = '0; cordy = 1'b0;

    // Reset: handshakes low while held, ready rises right after release.
    @(negedge clk);
    check("rst_r0", r0, 0);
    check("rst_r1", r1, 0);
    check("rst_ov", ov, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_r0", r0, 1);
    check("post_rst_r1", r1, 1);
    check("post_rst_ov", ov, 0);

    // Wire join.
    cordy = 1'b1; cv0 = 1'b1; cd0 = 16'h0012; cv1 = 1'b0;
    #1;
    check("comb_ov_lone", cov, 0);
    check("comb_r0_lone", cr0, 0);
    check("comb_r1_lone", cr1, 1);
    cv1 = 1'b1; cd1 = 16'h0034;
    #1;
    check("comb_ov", cov, 1);
    check("comb_d0", cod0, 16'h0012);
    check("comb_d1", cod1, 16'h0034);
    check("comb_r0", cr0, 1);
    check("comb_r1", cr1, 1);
    cordy = 1'b0;
    #1;
    check("comb_ov_bp", cov, 1);
    check("comb_r0_bp", cr0, 0);
    check("comb_r1_bp", cr1, 0);

    // Full-rate streaming 0..99 on both sides.
    n_out = 0; first_in = -1; log0.delete(); log1.delete();
    run_stream(100, 100, 100, 100, 400, 16'h0000, 16'h0000);
    check("strm_count", n_out, 100);
    check("strm_latency", first_out - first_in, 1);
    check("strm_rate", last_out - first_out, 99);
    if (log0.size() == 100) begin
      check("strm_first_d0", log0[0], 16'd0);
      check("strm_first_d1", log1[0], 16'd0);
      check("strm_last_d0", log0[99], 16'd99);
      check("strm_last_d1", log1[99], 16'd99);
    end

    // Imbalance: channel 0 alone fills its slice, then channel 1 catches up.
    n_out = 0; log0.delete(); log1.delete();
    @(posedge clk); #1;
    ordy = 1'b1; v0 = 1'b1; d0 = 16'h000A;
    @(negedge clk);
    check("imb_rdy_a", r0, 1);
    @(posedge clk); #1;
    d0 = 16'h000B;
    @(negedge clk);
    check("imb_rdy_b", r0, 1);
    @(posedge clk); #1;
    d0 = 16'h000C;
    @(negedge clk);
    check("imb_rdy_c", r0, 0);
    check("imb_ov_c", ov, 0);
    repeat (3) @(negedge clk);
    check("imb_stall_r0", r0, 0);
    check("imb_stall_ov", ov, 0);
    @(posedge clk); #1;
    v1 = 1'b1; d1 = 16'h0001; k = 1;
    for (int c = 0; c < 30 && (v0 || v1); c++) begin
      @(negedge clk);
      a0 = v0 && r0;
      a1 = v1 && r1;
      @(posedge clk); #1;
      if (a0) v0 = 1'b0;
      if (a1) begin
        k++;
        if (k > 3) v1 = 1'b0;
        else d1 = 16'(k);
      end
    end
    repeat (3) @(negedge clk);
    check("imb_count", n_out, 3);
    if (log0.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("imb_d0", log0[i], e0[i]);
        check("imb_d1", log1[i], e1[i]);
      end
    end

    // Random backpressure, 1000 beats.
    n_out = 0;
    run_stream(1000, 60, 70, 30, 12000, 16'h1000, 16'h8000);
    check("bp_count", n_out, 1000);

    // Reset with both slices full.
    @(posedge clk); #1;
    ordy = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 16'h00E0; d1 = 16'h00E1; f0 = 0; f1 = 0;
    for (int c = 0; c < 10 && (v0 || v1); c++) begin
      @(negedge clk);
      a0 = v0 && r0;
      a1 = v1 && r1;
      @(posedge clk); #1;
      if (a0) begin f0++; d0 = d0 + 16'd1; if (f0 == 2) v0 = 1'b0; end
      if (a1) begin f1++; d1 = d1 + 16'd1; if (f1 == 2) v1 = 1'b0; end
    end
    @(negedge clk);
    check("fill_r0", r0, 0);
    check("fill_r1", r1, 0);
    check("fill_ov", ov, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_r0", r0, 0);
    check("mid_rst_r1", r1, 0);
    check("mid_rst_ov", ov, 0);
    @(posedge clk); #1;
    rst = 1'b0; ordy = 1'b1;
    @(negedge clk);
    check("after_rst_r0", r0, 1);
    check("after_rst_r1", r1, 1);
    check("after_rst_ov", ov, 0);
    repeat (4) begin
      @(negedge clk);
      check("no_stale_ov", ov, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
